rst_ctrl: RTL and testbench

Parametrised clock-enable and reset controller that sits between the PLL and the `soc` core. It generates a prescaled clock-enable instead of a derived clock. It stretches reset for a programmable number of enable ticks and merges several synchronous reset requests. It adds a kickable watchdog, and reports the cause of the last reset plus a saturating reset count.

---
 rtl/rst_ctrl.sv | 129 ++++++++++++
 tb/tb_rst_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_ctrl.sv
// Clock-enable prescaler, stretched reset merger and kickable watchdog for the soc core.
// Reports the cause of the last reset and a saturating count of resets since rst.
module rst_ctrl #(
    parameter int unsigned PRESCALE_BITS = 4,
    parameter int unsigned STRETCH       = 5,
    parameter int unsigned N_REQ         = 2,
    parameter int unsigned WDOG_BITS     = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             wdog_en,
    input  logic             kick,
    output logic             ck_en,
    output logic             rst_out,
    output logic [N_REQ+1:0] cause,
    output logic [7:0]       rst_count
);
    localparam int unsigned CAUSE_W    = N_REQ + 2;
    localparam logic [7:0]  STRETCH_LD = 8'(STRETCH);
    localparam logic [7:0]  COUNT_MAX  = 8'hFF;

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         stretch_q;
    logic [7:0]         stretch_nxt;
    logic [CAUSE_W-1:0] cause_nxt;
    logic [7:0]         rst_count_nxt;
    logic               live_q;
    logic               tick;
    logic               req_any;
    logic               wdog_exp;

    // Prescaler: ck_en is high the cycle after the counter reaches all-ones.
    generate
        if (PRESCALE_BITS == 0) begin : g_no_pre
            assign ck_en = 1'b1;
        end else begin : g_pre
            logic [PRESCALE_BITS-1:0] pre_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pre_q <= '0;
                    ck_en <= 1'b0;
                end else begin
                    pre_q <= pre_q + PRESCALE_BITS'(1);
                    ck_en <= (pre_q == '1);
                end
            end
        end
    endgenerate

    // The enable seen while rst is still asserted is not a stretch tick.
    assign tick    = ck_en & live_q;
    assign req_any = |req;

    // Watchdog counts ticks in RUN; expiry is the increment out of all-ones.
    generate
        if (WDOG_BITS == 0) begin : g_no_wdog
            assign wdog_exp = 1'b0;
        end else begin : g_wdog
            logic [WDOG_BITS-1:0] wdog_q;
            assign wdog_exp = (state == RUN) && wdog_en && !kick && tick && (wdog_q == '1);
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wdog_q <= '0;
                end else if ((state != RUN) || !wdog_en || kick) begin
                    wdog_q <= '0;
                end else if (tick) begin
                    wdog_q <= wdog_q + WDOG_BITS'(1);
                end
            end
        end
    endgenerate

    // Next-state, stretch, cause and count.
    always_comb begin
        state_nxt     = state;
        stretch_nxt   = stretch_q;
        cause_nxt     = cause;
        rst_count_nxt = rst_count;
        case (state)
            HOLD: begin
                if (req_any) begin
                    stretch_nxt = STRETCH_LD;
                    cause_nxt   = cause | {1'b0, req, 1'b0};
                end else if (tick) begin
                    stretch_nxt = stretch_q - 8'd1;
                    if (stretch_q == 8'd1) begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                stretch_nxt = STRETCH_LD;
                if (req_any || wdog_exp) begin
                    state_nxt = HOLD;
                    cause_nxt = {wdog_exp, req, 1'b0};
                    if (rst_count != COUNT_MAX) begin
                        rst_count_nxt = rst_count + 8'd1;
                    end
                end
            end
            default: state_nxt = HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HOLD;
            stretch_q <= STRETCH_LD;
            cause     <= CAUSE_W'(1);
            rst_count <= '0;
            rst_out   <= 1'b1;
            live_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            stretch_q <= stretch_nxt;
            cause     <= cause_nxt;
            rst_count <= rst_count_nxt;
            rst_out   <= (state_nxt == HOLD);
            live_q    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rst_ctrl.sv
// Directed bench for rst_ctrl: main instance (PRESCALE 2, STRETCH 5, WDOG 4)
// and a corner instance (PRESCALE 0, STRETCH 1, no watchdog).
module tb_rst_ctrl;
    logic       clk = 1'b0;
    logic       rst_m, wdog_en_m, kick_m, ck_en_m, rst_out_m;
    logic [1:0] req_m;
    logic [3:0] cause_m;
    logic [7:0] rst_count_m;
    logic       rst_c, wdog_en_c, kick_c, ck_en_c, rst_out_c;
    logic [1:0] req_c;
    logic [3:0] cause_c;
    logic [7:0] rst_count_c;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    rst_ctrl #(.PRESCALE_BITS(2), .STRETCH(5), .N_REQ(2), .WDOG_BITS(4)) u_main (
        .clk(clk), .rst(rst_m), .req(req_m), .wdog_en(wdog_en_m), .kick(kick_m),
        .ck_en(ck_en_m), .rst_out(rst_out_m), .cause(cause_m), .rst_count(rst_count_m)
    );

    rst_ctrl #(.PRESCALE_BITS(0), .STRETCH(1), .N_REQ(2), .WDOG_BITS(0)) u_corner (
        .clk(clk), .rst(rst_c), .req(req_c), .wdog_en(wdog_en_c), .kick(kick_c),
        .ck_en(ck_en_c), .rst_out(rst_out_c), .cause(cause_c), .rst_count(rst_count_c)
    );

    // One clock; returns on the following negedge so outputs are stable.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        repeat (2) step();
        n_checks++;
        if (rst_out_m !== 1'b1 || ck_en_m !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_main rst_out/ck_en got=%b/%b exp=1/0", rst_out_m, ck_en_m);
        end
        n_checks++;
        if (cause_m !== 4'b0001 || rst_count_m !== 8'd0) begin
            n_fails++;
            $display("FAIL reset_main cause/count got=%b/%0d exp=0001/0", cause_m, rst_count_m);
        end
        n_checks++;
        if (rst_out_c !== 1'b1 || ck_en_c !== 1'b1 || cause_c !== 4'b0001) begin
            n_fails++;
            $display("FAIL reset_corner rst_out/ck_en/cause got=%b/%b/%b exp=1/1/0001",
                     rst_out_c, ck_en_c, cause_c);
        end
    endtask

    // Release rst and follow ck_en and rst_out up to cycle last.
    task automatic test_power_on(input int last, input string tag);
        logic e;
        rst_m = 1'b0;
        cyc   = -1;
        while (cyc < last) begin
            step();
            e = ((cyc % 4) == 3);
            n_checks++;
            if (ck_en_m !== e) begin
                n_fails++;
                $display("FAIL %s ck_en cyc=%0d got=%b exp=%b", tag, cyc, ck_en_m, e);
            end
            e = (cyc < 20);
            n_checks++;
            if (rst_out_m !== e) begin
                n_fails++;
                $display("FAIL %s rst_out cyc=%0d got=%b exp=%b", tag, cyc, rst_out_m, e);
            end
        end
        n_checks++;
        if (cause_m !== 4'b0001 || rst_count_m !== 8'd0) begin
            n_fails++;
            $display("FAIL %s cause/count got=%b/%0d exp=0001/0", tag, cause_m, rst_count_m);
        end
    endtask

    task automatic test_single_req();
        logic e;
        req_m = 2'b10;
        step();
        req_m = 2'b00;
        n_checks++;
        if (rst_out_m !== 1'b1 || cause_m !== 4'b0100 || rst_count_m !== 8'd1) begin
            n_fails++;
            $display("FAIL single_req entry rst_out/cause/count got=%b/%b/%0d exp=1/0100/1",
                     rst_out_m, cause_m, rst_count_m);
        end
        while (cyc < 44) begin
            step();
            e = (cyc < 44);
            n_checks++;
            if (rst_out_m !== e) begin
                n_fails++;
                $display("FAIL single_req release cyc=%0d got=%b exp=%b", cyc, rst_out_m, e);
            end
        end
    endtask

    task automatic test_extension();
        logic e;
        req_m = 2'b10;
        step();
        req_m = 2'b00;
        n_checks++;
        if (cause_m !== 4'b0100 || rst_count_m !== 8'd2) begin
            n_fails++;
            $display("FAIL extension entry cause/count got=%b/%0d exp=0100/2", cause_m, rst_count_m);
        end
        while (cyc < 56) step();
        req_m = 2'b01;
        step();
        req_m = 2'b00;
        n_checks++;
        if (rst_out_m !== 1'b1 || cause_m !== 4'b0110 || rst_count_m !== 8'd2) begin
            n_fails++;
            $display("FAIL extension reload rst_out/cause/count got=%b/%b/%0d exp=1/0110/2",
                     rst_out_m, cause_m, rst_count_m);
        end
        while (cyc < 76) begin
            step();
            e = (cyc < 76);
            n_checks++;
            if (rst_out_m !== e) begin
                n_fails++;
                $display("FAIL extension release cyc=%0d got=%b exp=%b", cyc, rst_out_m, e);
            end
        end
        n_checks++;
        if (cause_m !== 4'b0110) begin
            n_fails++;
            $display("FAIL extension cause_in_run got=%b exp=0110", cause_m);
        end
    endtask

    task automatic test_watchdog();
        logic e;
        wdog_en_m = 1'b1;
        while (cyc < 140) begin
            step();
            e = (cyc >= 140);
            n_checks++;
            if (rst_out_m !== e) begin
                n_fails++;
                $display("FAIL watchdog expiry cyc=%0d got=%b exp=%b", cyc, rst_out_m, e);
            end
        end
        n_checks++;
        if (cause_m !== 4'b1000 || rst_count_m !== 8'd3) begin
            n_fails++;
            $display("FAIL watchdog cause/count got=%b/%0d exp=1000/3", cause_m, rst_count_m);
        end
        while (cyc < 160) begin
            step();
            e = (cyc < 160);
            n_checks++;
            if (rst_out_m !== e) begin
                n_fails++;
                $display("FAIL watchdog release cyc=%0d got=%b exp=%b", cyc, rst_out_m, e);
            end
        end
    endtask

    task automatic test_kick_and_reset();
        for (int k = 0; k < 800; k++) begin
            kick_m = ((k % 40) == 0);
            step();
            n_checks++;
            if (rst_out_m !== 1'b0) begin
                n_fails++;
                $display("FAIL kick no_reset cyc=%0d got=%b exp=0", cyc, rst_out_m);
            end
        end
        kick_m = 1'b0;
        repeat (6) step();
        #2 rst_m = 1'b1;
        #1;
        n_checks++;
        if (rst_out_m !== 1'b1 || ck_en_m !== 1'b0 || cause_m !== 4'b0001 || rst_count_m !== 8'd0) begin
            n_fails++;
            $display("FAIL async_rst rst_out/ck_en/cause/count got=%b/%b/%b/%0d exp=1/0/0001/0",
                     rst_out_m, ck_en_m, cause_m, rst_count_m);
        end
        @(negedge clk);
        wdog_en_m = 1'b0;
    endtask

    task automatic test_simultaneous();
        wdog_en_m = 1'b1;
        while (cyc < 83) begin
            step();
            n_checks++;
            if (rst_out_m !== 1'b0) begin
                n_fails++;
                $display("FAIL simultaneous pre cyc=%0d got=%b exp=0", cyc, rst_out_m);
            end
        end
        req_m = 2'b01;
        step();
        req_m = 2'b00;
        n_checks++;
        if (rst_out_m !== 1'b1 || cause_m !== 4'b1010 || rst_count_m !== 8'd1) begin
            n_fails++;
            $display("FAIL simultaneous rst_out/cause/count got=%b/%b/%0d exp=1/1010/1",
                     rst_out_m, cause_m, rst_count_m);
        end
        wdog_en_m = 1'b0;
    endtask

    task automatic test_corner();
        logic [7:0] e;
        rst_c = 1'b0;
        step();
        n_checks++;
        if (rst_out_c !== 1'b1 || ck_en_c !== 1'b1) begin
            n_fails++;
            $display("FAIL corner first_edge rst_out/ck_en got=%b/%b exp=1/1", rst_out_c, ck_en_c);
        end
        repeat (3) begin
            step();
            n_checks++;
            if (rst_out_c !== 1'b0 || ck_en_c !== 1'b1) begin
                n_fails++;
                $display("FAIL corner run rst_out/ck_en got=%b/%b exp=0/1", rst_out_c, ck_en_c);
            end
        end
        for (int p = 1; p <= 256; p++) begin
            req_c = 2'b01;
            step();
            req_c = 2'b00;
            step();
            if (p == 1 || p == 254 || p == 255 || p == 256) begin
                e = (p < 255) ? 8'(p) : 8'd255;
                n_checks++;
                if (rst_count_c !== e || rst_out_c !== 1'b0) begin
                    n_fails++;
                    $display("FAIL corner saturate p=%0d count/rst_out got=%0d/%b exp=%0d/0",
                             p, rst_count_c, rst_out_c, e);
                end
            end
        end
        n_checks++;
        if (cause_c !== 4'b0010) begin
            n_fails++;
            $display("FAIL corner cause got=%b exp=0010", cause_c);
        end
    endtask

    initial begin
        rst_m = 1'b1; req_m = 2'b00; wdog_en_m = 1'b0; kick_m = 1'b0;
        rst_c = 1'b1; req_c = 2'b00; wdog_en_c = 1'b0; kick_c = 1'b0;
        test_reset();
        test_power_on(24, "power_on");
        test_single_req();
        test_extension();
        test_watchdog();
        test_kick_and_reset();
        test_power_on(20, "rerelease");
        test_simultaneous();
        test_corner();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
